// File: rtl/vid_mem_arbiter_if.sv
// Signal bundle between the memory arbiter and its three neighbours:
// the video fetcher, the CPU bus and the SDRAM controller front end.
interface vid_mem_arbiter_if #(
    parameter int AW = 24
);
    logic          vid_req;
    logic          vid_frame_start;
    logic [AW-1:0] fb_base;
    logic [31:0]   vid_data;
    logic          vid_valid;
    logic          vid_overflow;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;

    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    // Arbiter side
    modport slave (
        input  vid_req, vid_frame_start, fb_base,
        output vid_data, vid_valid, vid_overflow,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // Environment side (video controller, CPU, memory)
    modport master (
        output vid_req, vid_frame_start, fb_base,
        input  vid_data, vid_valid, vid_overflow,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/vid_mem_arbiter.sv
// Shares one word-addressed memory port between scanout video fetches (queued,
// prioritised) and the CPU, which is guaranteed a slot after VID_RUN video grants.
module vid_mem_arbiter #(
    parameter int AW       = 24,
    parameter int VID_PEND = 3,
    parameter int VID_RUN  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    vid_mem_arbiter_if.slave   bus
);
    localparam int PW = $clog2(VID_PEND + 1);
    localparam int RW = $clog2(VID_RUN + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(VID_PEND);
    localparam logic [RW-1:0] RUN_MAX  = RW'(VID_RUN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_V_ISS  = 3'd1,
        S_V_WAIT = 3'd2,
        S_C_ISS  = 3'd3,
        S_C_WAIT = 3'd4,
        S_C_DONE = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [PW-1:0] r_pend;
    logic [AW-1:0] r_offset;
    logic [AW-1:0] r_base_q;
    logic [RW-1:0] r_run;
    logic          r_vid_drop;

    logic          r_mem_valid;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_vid_data;
    logic          r_vid_valid;
    logic          r_vid_overflow;
    logic [31:0]   r_cpu_rdata;

    logic          w_pend_nz;
    logic          w_cpu_forced;
    logic          w_v_launch;
    logic          w_c_launch;
    logic          w_v_accept;
    logic          w_c_accept;
    logic          w_v_rdone;
    logic          w_c_rdone;
    logic          w_v_count;
    logic          w_cpu_ack;

    assign w_pend_nz    = (r_pend != '0);
    assign w_cpu_forced = bus.cpu_req && (r_run == RUN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pend_nz && !w_cpu_forced) begin
                    w_state_next = S_V_ISS;
                end else if (bus.cpu_req) begin
                    w_state_next = S_C_ISS;
                end
            end
            S_V_ISS:  if (bus.mem_ready)  w_state_next = S_V_WAIT;
            S_V_WAIT: if (bus.mem_rvalid) w_state_next = S_IDLE;
            S_C_ISS:  if (bus.mem_ready)  w_state_next = r_mem_we ? S_C_DONE : S_C_WAIT;
            S_C_WAIT: if (bus.mem_rvalid) w_state_next = S_C_DONE;
            S_C_DONE: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_v_launch = (r_state == S_IDLE) && (w_state_next == S_V_ISS);
        w_c_launch = (r_state == S_IDLE) && (w_state_next == S_C_ISS);
        w_v_accept = (r_state == S_V_ISS) && bus.mem_ready;
        w_c_accept = (r_state == S_C_ISS) && bus.mem_ready;
        w_v_rdone  = (r_state == S_V_WAIT) && bus.mem_rvalid;
        w_c_rdone  = (r_state == S_C_WAIT) && bus.mem_rvalid;
        w_cpu_ack  = (r_state == S_C_DONE);
        // A fetch orphaned by a frame restart must not consume queue or address.
        w_v_count  = w_v_accept && !r_vid_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend         <= '0;
            r_offset       <= '0;
            r_base_q       <= '0;
            r_run          <= '0;
            r_vid_drop     <= 1'b0;
            r_vid_overflow <= 1'b0;
        end else begin
            if (bus.vid_frame_start) begin
                r_base_q <= bus.fb_base;
                r_offset <= '0;
                r_pend   <= bus.vid_req ? PW'(1) : '0;
            end else begin
                if (w_v_count) begin
                    r_offset <= r_offset + AW'(1);
                end
                if (bus.vid_req && !w_v_count) begin
                    if (r_pend == PEND_MAX) begin
                        r_vid_overflow <= 1'b1;
                    end else begin
                        r_pend <= r_pend + PW'(1);
                    end
                end else if (!bus.vid_req && w_v_count) begin
                    r_pend <= r_pend - PW'(1);
                end
            end

            // Includes the launch cycle: that command already carries the old base.
            if (w_v_rdone) begin
                r_vid_drop <= 1'b0;
            end else if (bus.vid_frame_start &&
                         (r_state == S_V_ISS || r_state == S_V_WAIT || w_v_launch)) begin
                r_vid_drop <= 1'b1;
            end

            if (w_c_accept) begin
                r_run <= '0;
            end else if (w_v_accept && bus.cpu_req && (r_run != RUN_MAX)) begin
                r_run <= r_run + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_v_launch) begin
                r_mem_valid <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= r_base_q + r_offset;
            end else if (w_c_launch) begin
                r_mem_valid <= 1'b1;
                r_mem_we    <= bus.cpu_we;
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= bus.cpu_wdata;
            end else if (w_v_accept || w_c_accept) begin
                r_mem_valid <= 1'b0;
            end

            r_vid_valid <= 1'b0;
            if (w_v_rdone && !r_vid_drop && !bus.vid_frame_start) begin
                r_vid_data  <= bus.mem_rdata;
                r_vid_valid <= 1'b1;
            end

            if (w_c_rdone) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.vid_data     = r_vid_data;
    assign bus.vid_valid    = r_vid_valid;
    assign bus.vid_overflow = r_vid_overflow;
    assign bus.cpu_ack      = w_cpu_ack;
    assign bus.cpu_rdata    = r_cpu_rdata;
endmodule
